// File: rtl/bpi_intrf_fsm.sv
// BPI NOR flash cycle sequencer: one timed write or read cycle per EXECUTE pulse.
// Optional triplicated state/counter/path with per-cycle majority reload.
module bpi_intrf_fsm #(
  parameter int unsigned LATCH_CYC = 2,
  parameter int unsigned WE_CYC    = 4,
  parameter int unsigned OE_CYC    = 8,
  parameter int unsigned TMR       = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic EXECUTE,
  input  logic READ,
  input  logic WRITE,
  output logic BUSY,
  output logic CAP,
  output logic E,
  output logic L,
  output logic W,
  output logic G,
  output logic LOAD
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CAPT  = 3'd1,
    S_DEC   = 3'd2,
    S_LATCH = 3'd3,
    S_WR    = 3'd4,
    S_RD    = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  localparam logic [3:0] LATCH_N = 4'(LATCH_CYC - 1);
  localparam logic [3:0] WE_N    = 4'(WE_CYC - 1);
  localparam logic [3:0] OE_N    = 4'(OE_CYC - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       path_rd, path_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    path_nx  = path_rd;
    if (cnt != '0)
      cnt_nx = cnt - 4'd1;
    unique case (state)
      S_IDLE:  if (EXECUTE) state_nx = S_CAPT;
      S_CAPT:  state_nx = S_DEC;
      S_DEC: begin
        if (READ ^ WRITE) begin
          state_nx = S_LATCH;
          cnt_nx   = LATCH_N;
          path_nx  = READ;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_LATCH: begin
        if (cnt == '0) begin
          state_nx = path_rd ? S_RD : S_WR;
          cnt_nx   = path_rd ? OE_N : WE_N;
        end
      end
      S_WR, S_RD: if (cnt == '0) state_nx = S_HOLD;
      S_HOLD:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  generate
    if (TMR != 0) begin : g_tmr
      logic [2:0] st_q0, st_q1, st_q2;
      logic [3:0] cnt_q0, cnt_q1, cnt_q2;
      logic       path_q0, path_q1, path_q2;

      // Every copy reloads from the voted next value, so a single upset heals in one edge.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          st_q0   <= '0;
          st_q1   <= '0;
          st_q2   <= '0;
          cnt_q0  <= '0;
          cnt_q1  <= '0;
          cnt_q2  <= '0;
          path_q0 <= 1'b0;
          path_q1 <= 1'b0;
          path_q2 <= 1'b0;
        end else begin
          st_q0   <= state_nx;
          st_q1   <= state_nx;
          st_q2   <= state_nx;
          cnt_q0  <= cnt_nx;
          cnt_q1  <= cnt_nx;
          cnt_q2  <= cnt_nx;
          path_q0 <= path_nx;
          path_q1 <= path_nx;
          path_q2 <= path_nx;
        end
      end

      assign state   = state_t'((st_q0 & st_q1) | (st_q0 & st_q2) | (st_q1 & st_q2));
      assign cnt     = (cnt_q0 & cnt_q1) | (cnt_q0 & cnt_q2) | (cnt_q1 & cnt_q2);
      assign path_rd = (path_q0 & path_q1) | (path_q0 & path_q2) | (path_q1 & path_q2);
    end else begin : g_single
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          state   <= S_IDLE;
          cnt     <= '0;
          path_rd <= 1'b0;
        end else begin
          state   <= state_nx;
          cnt     <= cnt_nx;
          path_rd <= path_nx;
        end
      end
    end
  endgenerate

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      BUSY <= 1'b0;
      CAP  <= 1'b0;
      E    <= 1'b0;
      L    <= 1'b0;
      W    <= 1'b0;
      G    <= 1'b0;
      LOAD <= 1'b0;
    end else begin
      BUSY <= (state_nx != S_IDLE);
      CAP  <= (state_nx == S_CAPT);
      E    <= (state_nx == S_LATCH) || (state_nx == S_WR) ||
              (state_nx == S_RD) || (state_nx == S_HOLD);
      L    <= (state_nx == S_LATCH);
      W    <= (state_nx == S_WR);
      G    <= (state_nx == S_RD);
      LOAD <= (state_nx == S_RD) && (cnt_nx == '0);
    end
  end

endmodule

// File: tb/tb_bpi_intrf_fsm.sv
// Bench for bpi_intrf_fsm: timeline model checked every cycle against a plain and a TMR
// instance, plus literal per-cycle waveform masks for the directed write/read/standby cases.
module tb_bpi_intrf_fsm;

  localparam int LC = 2;
  localparam int WC = 4;
  localparam int OC = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic EXECUTE = 1'b0;
  logic READ = 1'b0;
  logic WRITE = 1'b0;

  logic busy0, cap0, e0, l0, w0, g0, load0;
  logic busy1, cap1, e1, l1, w1, g1, load1;

  int n_cmp = 0;
  int n_err = 0;

  bpi_intrf_fsm #(.LATCH_CYC(LC), .WE_CYC(WC), .OE_CYC(OC), .TMR(0)) dut (
    .CLK(CLK), .RST(RST), .EXECUTE(EXECUTE), .READ(READ), .WRITE(WRITE),
    .BUSY(busy0), .CAP(cap0), .E(e0), .L(l0), .W(w0), .G(g0), .LOAD(load0)
  );

  bpi_intrf_fsm #(.LATCH_CYC(LC), .WE_CYC(WC), .OE_CYC(OC), .TMR(1)) dut_t (
    .CLK(CLK), .RST(RST), .EXECUTE(EXECUTE), .READ(READ), .WRITE(WRITE),
    .BUSY(busy1), .CAP(cap1), .E(e1), .L(l1), .W(w1), .G(g1), .LOAD(load1)
  );

  always #5 CLK = ~CLK;

  logic [6:0] o0, o1;
  assign o0 = {busy0, cap0, e0, l0, w0, g0, load0};
  assign o1 = {busy1, cap1, e1, l1, w1, g1, load1};

  // Model: m_t = cycle number within the current operation (0 = idle), m_rd = read op.
  int m_t = 0;
  bit m_rd = 1'b0;

  function automatic int last_cycle(bit rd);
    return 2 + LC + (rd ? OC : WC) + 1;
  endfunction

  function automatic logic [6:0] model_out(int t, bit rd);
    int lat_end, str_end;
    logic [6:0] r;
    lat_end = 2 + LC;
    str_end = lat_end + (rd ? OC : WC);
    r = '0;
    if (t >= 1) r[6] = 1'b1;
    if (t == 1) r[5] = 1'b1;
    if (t >= 3) begin
      r[4] = 1'b1;
      r[3] = (t <= lat_end);
      r[2] = !rd && (t > lat_end) && (t <= str_end);
      r[1] = rd && (t > lat_end) && (t <= str_end);
      r[0] = rd && (t == str_end);
    end
    return r;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_t  = 0;
      m_rd = 1'b0;
    end else if (m_t == 0) begin
      if (EXECUTE) m_t = 1;
    end else if (m_t == 1) begin
      m_t = 2;
    end else if (m_t == 2) begin
      if (READ ^ WRITE) begin
        m_rd = READ;
        m_t  = 3;
      end else begin
        m_t = 0;
      end
    end else if (m_t == last_cycle(m_rd)) begin
      m_t = 0;
    end else begin
      m_t = m_t + 1;
    end
  end

  always @(negedge CLK) begin
    logic [6:0] ex;
    ex = model_out(m_t, m_rd);
    n_cmp = n_cmp + 2;
    if (o0 !== ex) begin
      n_err = n_err + 1;
      $display("FAIL cycle_plain t=%0d got=%b exp=%b (BUSY CAP E L W G LOAD) @%0t", m_t, o0, ex, $time);
    end
    if (o1 !== ex) begin
      n_err = n_err + 1;
      $display("FAIL cycle_tmr t=%0d got=%b exp=%b (BUSY CAP E L W G LOAD) @%0t", m_t, o1, ex, $time);
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  logic [15:0] mask [7];
  string sig_name [7] = '{"LOAD", "G", "W", "L", "E", "CAP", "BUSY"};

  task automatic idle_cycles(input int n);
    EXECUTE = 1'b0;
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // Records the plain instance's outputs for cycles 1..15 of one operation into mask[] (bit = cycle).
  task automatic run_op(input logic rd, input logic wr, input bit tog);
    for (int k = 0; k < 7; k++) mask[k] = '0;
    READ = rd;
    WRITE = wr;
    EXECUTE = 1'b1;
    for (int c = 1; c < 16; c++) begin
      @(negedge CLK);
      for (int k = 0; k < 7; k++) mask[k][c] = o0[k];
      if (tog && c < 14) EXECUTE = 1'($urandom_range(0, 1));
      else if (tog && c == 14) EXECUTE = 1'b1;
      else EXECUTE = 1'b0;
    end
    idle_cycles(20);
  endtask

  task automatic check_masks(input string tag, input logic [15:0] exp [7]);
    for (int k = 0; k < 7; k++) check({tag, "_", sig_name[k]}, mask[k], exp[k]);
  endtask

  // Index order matches o0 bits: [0]=LOAD [1]=G [2]=W [3]=L [4]=E [5]=CAP [6]=BUSY.
  logic [15:0] exp_wr  [7] = '{16'h0000, 16'h0000, 16'h01E0, 16'h0018, 16'h03F8, 16'h0002, 16'h03FE};
  logic [15:0] exp_rd  [7] = '{16'h1000, 16'h1FE0, 16'h0000, 16'h0018, 16'h3FF8, 16'h0002, 16'h3FFE};
  logic [15:0] exp_sb  [7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0006};
  logic [15:0] exp_tog [7] = '{16'h1000, 16'h1FE0, 16'h0000, 16'h0018, 16'h3FF8, 16'h8002, 16'hBFFE};

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_plain", {9'd0, o0}, 16'h0000);
    check("reset_tmr", {9'd0, o1}, 16'h0000);
    RST = 1'b1;
    idle_cycles(2);

    run_op(1'b0, 1'b1, 1'b0);
    check_masks("write", exp_wr);
    run_op(1'b1, 1'b0, 1'b0);
    check_masks("read", exp_rd);
    run_op(1'b0, 1'b0, 1'b0);
    check_masks("op00", exp_sb);
    run_op(1'b1, 1'b1, 1'b0);
    check_masks("op11", exp_sb);
    run_op(1'b1, 1'b0, 1'b1);
    check_masks("read_exec_held", exp_tog);

    // Asynchronous reset in the middle of a read.
    READ = 1'b1;
    WRITE = 1'b0;
    EXECUTE = 1'b1;
    @(negedge CLK);
    EXECUTE = 1'b0;
    repeat (7) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("async_rst_plain", {9'd0, o0}, 16'h0000);
    check("async_rst_tmr", {9'd0, o1}, 16'h0000);
    @(negedge CLK);
    RST = 1'b1;
    EXECUTE = 1'b1;
    @(negedge CLK);
    EXECUTE = 1'b0;
    check("cap_after_rst", {15'd0, cap0}, 16'h0001);
    idle_cycles(20);

    // Single-copy state upset mid-WR on the TMR instance; model checks keep running.
    READ = 1'b0;
    WRITE = 1'b1;
    EXECUTE = 1'b1;
    @(negedge CLK);
    EXECUTE = 1'b0;
    repeat (5) @(negedge CLK);
    force dut_t.g_tmr.st_q1 = 3'b111;
    @(negedge CLK);
    release dut_t.g_tmr.st_q1;
    idle_cycles(20);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      RST = 1'b1;
      EXECUTE = ($urandom_range(0, 3) == 0);
      READ = 1'($urandom_range(0, 1));
      WRITE = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) #2 RST = 1'b0;
    end
    @(negedge CLK);
    RST = 1'b1;
    idle_cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
